// File: rtl/cra256_operand_loader.sv
// Purpose: assembles two N-bit adder operands plus carry-in from a W-bit beat stream.
// Latency: op_valid rises one cycle after the last beat is accepted.
// Backpressure: in_ready is low while an operand set is held; op_ready releases the hold.
module cra256_operand_loader #(
    parameter  int N     = 256,
    parameter  int W     = 32,
    localparam int BEATS = N / W,
    localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  in_a,
    input  logic [W-1:0]  in_b,
    input  logic          in_cin,
    output logic [N-1:0]  a,
    output logic [N-1:0]  b,
    output logic          cin,
    output logic          op_valid,
    input  logic          op_ready,
    output logic [CW-1:0] beat_cnt
);

    if ((N % W) != 0) begin : g_bad_width
        $error("cra256_operand_loader: N must be a multiple of W");
    end

    typedef enum logic [0:0] {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t        state_q;
    state_t        state_d;
    logic [CW-1:0] cnt_d;
    logic          vld_d;
    logic          accept;
    logic          wr_en;
    logic          last_beat;

    assign in_ready  = (state_q == FILL) && rst_n;
    assign accept    = in_valid && in_ready;
    assign last_beat = (beat_cnt == CW'(BEATS - 1));

    // Flush wins over both a beat and an op handshake in the same cycle.
    assign wr_en = accept && !flush;

    always_comb begin
        state_d = state_q;
        cnt_d   = beat_cnt;
        vld_d   = op_valid;
        if (flush) begin
            state_d = FILL;
            cnt_d   = '0;
            vld_d   = 1'b0;
        end else begin
            case (state_q)
                FILL: begin
                    if (accept) begin
                        if (last_beat) begin
                            cnt_d   = '0;
                            state_d = HOLD;
                            vld_d   = 1'b1;
                        end else begin
                            cnt_d = beat_cnt + CW'(1);
                        end
                    end
                end
                HOLD: begin
                    if (op_valid && op_ready) begin
                        state_d = FILL;
                        vld_d   = 1'b0;
                    end
                end
                default: begin
                    state_d = FILL;
                    cnt_d   = '0;
                    vld_d   = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= FILL;
            beat_cnt <= '0;
            op_valid <= 1'b0;
            a        <= '0;
            b        <= '0;
            cin      <= 1'b0;
        end else begin
            state_q  <= state_d;
            beat_cnt <= cnt_d;
            op_valid <= vld_d;
            // Only the addressed word changes; stale words from earlier sets persist.
            if (wr_en) begin
                a[int'(beat_cnt) * W +: W] <= in_a;
                b[int'(beat_cnt) * W +: W] <= in_b;
                if (beat_cnt == '0) begin
                    cin <= in_cin;
                end
            end
        end
    end

endmodule
